// File: rtl/nic_access_ctrl.sv
// ============================================================================
// Module   : nic_access_ctrl
// Purpose  : Round-robin sharing of one NIC between NREQ requesters; sequences
//            status polling and buffer access for send / recv transactions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nic_access_ctrl #(
    parameter int NREQ     = 2,
    parameter int POLL_MAX = 16,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_op,
    input  logic [64*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      done,
    output logic [NREQ-1:0]      err,
    output logic [63:0]          rsp_data,
    output logic [1:0]           nic_addr,
    output logic [63:0]          nic_d_in,
    output logic                 nic_en,
    output logic                 nic_wr_en,
    input  logic [63:0]          nic_d_out
);

    localparam int               c_idx_w    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CNT_W-1:0] c_poll_max = CNT_W'(POLL_MAX);
    localparam logic [1:0]       c_in_buf   = 2'b00;
    localparam logic [1:0]       c_in_stat  = 2'b01;
    localparam logic [1:0]       c_out_buf  = 2'b10;
    localparam logic [1:0]       c_out_stat = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POLL  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_READ  = 3'd4,
        S_RWAIT = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_idx_w-1:0]   r_rr_ptr;
    logic [c_idx_w-1:0]   r_gnt;
    logic                 r_op;
    logic [63:0]          r_data;
    logic [CNT_W-1:0]     r_poll_cnt;

    logic [NREQ-1:0]      r_done;
    logic [NREQ-1:0]      r_err;
    logic [63:0]          r_rsp_data;
    logic [1:0]           r_nic_addr;
    logic [63:0]          r_nic_d_in;
    logic                 r_nic_en;
    logic                 r_nic_wr_en;

    logic                 w_any;
    logic [c_idx_w-1:0]   w_gnt;
    logic [c_idx_w-1:0]   w_idx;
    logic                 w_op_eff;
    logic                 w_timeout;
    logic                 w_status;
    logic [NREQ-1:0]      w_gnt_onehot;

    // Scan downward so the candidate closest to r_rr_ptr is the last one kept.
    always_comb begin
        w_any = 1'b0;
        w_gnt = '0;
        w_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = c_idx_w'((int'(r_rr_ptr) + k) % NREQ);
            if (req_valid[w_idx]) begin
                w_any = 1'b1;
                w_gnt = w_idx;
            end
        end
    end

    assign w_status     = nic_d_out[63];
    assign w_op_eff     = (r_state == S_IDLE) ? req_op[w_gnt] : r_op;
    assign w_gnt_onehot = NREQ'(1) << r_gnt;

    always_comb begin
        w_state_next = r_state;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE:  if (w_any) w_state_next = S_POLL;
            S_POLL:  w_state_next = S_WAIT;
            S_WAIT: begin
                if (!r_op && !w_status) begin
                    w_state_next = S_WRITE;
                end else if (r_op && w_status) begin
                    w_state_next = S_READ;
                end else if ((POLL_MAX != 0) && (r_poll_cnt == c_poll_max)) begin
                    w_state_next = S_DONE;
                    w_timeout    = 1'b1;
                end else begin
                    w_state_next = S_POLL;
                end
            end
            S_WRITE: w_state_next = S_DONE;
            S_READ:  w_state_next = S_RWAIT;
            S_RWAIT: w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr   <= '0;
            r_gnt      <= '0;
            r_op       <= 1'b0;
            r_data     <= '0;
            r_poll_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt      <= w_gnt;
                        r_op       <= req_op[w_gnt];
                        r_data     <= req_data[64*w_gnt +: 64];
                        r_poll_cnt <= '0;
                    end
                end
                S_POLL: r_poll_cnt <= r_poll_cnt + 1'b1;
                S_DONE: r_rr_ptr <= (r_gnt == c_idx_w'(NREQ - 1)) ? '0 : r_gnt + 1'b1;
                default: ;
            endcase
        end
    end

    // Outputs are registered from the next state so each pin is valid for the
    // whole cycle the FSM spends in the corresponding state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done      <= '0;
            r_err       <= '0;
            r_rsp_data  <= '0;
            r_nic_addr  <= '0;
            r_nic_d_in  <= '0;
            r_nic_en    <= 1'b0;
            r_nic_wr_en <= 1'b0;
        end else begin
            r_nic_en    <= (w_state_next == S_POLL) || (w_state_next == S_WRITE)
                           || (w_state_next == S_READ);
            r_nic_wr_en <= (w_state_next == S_WRITE);
            r_done      <= (w_state_next == S_DONE && !w_timeout) ? w_gnt_onehot : '0;
            r_err       <= (w_state_next == S_DONE &&  w_timeout) ? w_gnt_onehot : '0;

            case (w_state_next)
                S_POLL:  r_nic_addr <= w_op_eff ? c_in_stat : c_out_stat;
                S_WRITE: begin
                    r_nic_addr <= c_out_buf;
                    r_nic_d_in <= r_data;
                end
                S_READ:  r_nic_addr <= c_in_buf;
                default: ;
            endcase

            if (r_state == S_RWAIT) begin
                r_rsp_data <= nic_d_out;
            end
        end
    end

    assign done      = r_done;
    assign err       = r_err;
    assign rsp_data  = r_rsp_data;
    assign nic_addr  = r_nic_addr;
    assign nic_d_in  = r_nic_d_in;
    assign nic_en    = r_nic_en;
    assign nic_wr_en = r_nic_wr_en;

endmodule

`default_nettype wire

// File: doc/nic_access_ctrl.md
Name: nic_access_ctrl

Overview:
- Processor-side controller that shares one cardinal NIC between NREQ requesters (cores, DMA engines).
- Each requester issues whole "send" or "recv" transactions. The controller sequences the NIC register protocol for each one:
  - send: poll the output status register, then write the output buffer.
  - recv: poll the input status register, then read the input buffer.
- Arbitration between requesters is round-robin.
- Drives the NIC's addr/d_in/nicEn/nicWrEn pins and consumes its registered d_out.

Parameters:
- NREQ, 2, number of requesters (2..4).
- POLL_MAX, 16, maximum status polls per transaction before abort; 0 = poll forever.
- CNT_W, 16, width of the poll counter; POLL_MAX must be < 2^CNT_W.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  in  NREQ  per-requester request; held high until that requester's done or err pulse.
- req_op  in  NREQ  per-requester operation: 0 = send, 1 = recv.
- req_data  in  64*NREQ  send payload; slice i belongs to requester i.
- done  out  NREQ  one-cycle pulse per requester on successful completion.
- err  out  NREQ  one-cycle pulse per requester on poll timeout.
- rsp_data  out  64  received packet; valid in the cycle done[i] pulses for a recv; holds otherwise.
- nic_addr  out  2  to NIC addr (00 in-buf, 01 in-status, 10 out-buf, 11 out-status).
- nic_d_in  out  64  to NIC d_in.
- nic_en  out  1  to NIC nicEn.
- nic_wr_en  out  1  to NIC nicWrEn.
- nic_d_out  in  64  from NIC d_out; reflects a read issued in the previous cycle; status bit is bit 63.

Behaviour:
- Reset (async, reset=0): state=IDLE, rr_ptr=0, poll_cnt=0, and all outputs 0 (done, err, rsp_data, nic_addr, nic_d_in, nic_en, nic_wr_en).
- All outputs are driven from flops. nic_en is 1 only in POLL, WRITE and READ; nic_wr_en is 1 only in WRITE.
- IDLE:
  - If any req_valid is set, grant the first set bit scanning from rr_ptr upward, wrapping at NREQ.
  - Capture g, req_op[g] and req_data[g]; clear poll_cnt; go to POLL.
  - Requests that drop before they are granted are ignored.
  - A granted transaction completes even if req_valid[g] drops.
- POLL: nic_en=1, nic_wr_en=0, nic_addr = 11 (send) or 01 (recv); poll_cnt++; go to WAIT.
- WAIT: evaluate s = nic_d_out[63].
  - send and s=0: go to WRITE.
  - recv and s=1: go to READ.
  - Otherwise, if POLL_MAX!=0 and poll_cnt==POLL_MAX: go to DONE with err flag set.
  - Otherwise: return to POLL.
- WRITE: nic_en=1, nic_wr_en=1, nic_addr=10, nic_d_in=captured data; go to DONE.
- READ: nic_en=1, nic_wr_en=0, nic_addr=00; go to RWAIT.
- RWAIT: rsp_data <= nic_d_out; go to DONE.
- DONE:
  - Pulse done[g], or err[g] if the err flag is set.
  - rr_ptr <= (g+1) mod NREQ.
  - Go to IDLE. No new grant is made in this cycle.
- Latency, measured from the IDLE cycle where the request is seen (cycle 0):
  - send with NIC empty: POLL c1, WAIT c2, WRITE c3, done c4.
  - recv with data present: READ c3, RWAIT c4, done c5.
  - Each failed poll adds 2 cycles.
- nic_d_in holds its last written value. The NIC ignores it unless nic_wr_en is high.
- Timeout: no NIC write or read-buffer access is issued; rsp_data is unchanged.
- Simultaneous requests are served round-robin. A requester that re-asserts immediately after its done waits for any others pending.
- Reset mid-transaction:
  - NIC control outputs drop to 0 asynchronously.
  - The transaction is discarded; no done/err is issued.
  - After release, arbitration restarts from requester 0.
- Only one transaction is outstanding at a time. NIC side effects:
  - A send clears nothing in the NIC.
  - A recv buffer read clears the NIC input status.

Test Plan:
- Reset, then hold reset=0 for 3 cycles with random inputs -> all outputs 0; after release, state IDLE and nic_en=0.
- Requester 0 send of 0x8000_0000_0000_00AA with NIC output status 0 -> status read (addr 11) in c1; WRITE in c3 with addr=10, d_in=0x8000_0000_0000_00AA, wr_en=1; done[0]=1 in c4 only.
- Requester 1 recv; NIC input status 0 for 3 polls, then 1; input buffer holds 0x0123_4567_89AB_CDEF -> 4 POLL cycles, then READ with addr=00; done[1] asserted with rsp_data=0x0123_4567_89AB_CDEF.
- Both requesters continuously valid with sends, NIC always empty -> grants alternate 0,1,0,1; done pulses 5 cycles apart; never the same index twice in a row.
- POLL_MAX=4, send, NIC output status stuck at 1 -> exactly 4 status reads; err[0] pulses; no cycle with nic_wr_en=1; done stays 0.
- reset driven low during the WRITE cycle -> nic_en and nic_wr_en fall without waiting for a clock edge; no done pulse; the next request after release is granted to the lowest-index valid requester.
